// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Holds the tag-pipe entry layout, the register-file select code and the
// elaboration-time helpers used by fwd_tag_pipe and fwd_scoreboard.
package fwd_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } fwd_entry_t;

    localparam int ENTRY_W = $bits(fwd_entry_t);

    // Ceiling log2, used to size the per-operand forward select.
    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A producer matches a source only if it really writes and the source is not x0.
    function automatic logic entry_match(input fwd_entry_t entry,
                                         input logic [REG_ADDR_W-1:0] src);
        return entry.valid && (entry.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Tag shift register tracking {valid, rd, is_load} for N_STAGES stages after EX.
// Entry for stage k (1-based) sits at entries_o[(k-1)*ENTRY_W +: ENTRY_W].
module fwd_tag_pipe
    import fwd_pkg::*;
#(
    parameter int N_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        freeze_i,
    input  fwd_entry_t                  entry_i,
    output logic [N_STAGES*ENTRY_W-1:0] entries_o
);

    fwd_entry_t [N_STAGES-1:0] stage_reg;

    // Shift one stage per unfrozen edge; the oldest entry falls off the end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_reg <= '0;
        end else if (!freeze_i) begin
            stage_reg[0] <= entry_i;
            for (int k = 1; k < N_STAGES; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_flat
        assign entries_o[gi*ENTRY_W +: ENTRY_W] = stage_reg[gi];
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard controller with an internal tag pipeline.
// Optional statistics counters are built only when FWD_STATS_EN is defined;
// otherwise fwd_cnt_o and stall_cnt_o are tied to zero.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int N_STAGES   = 2,
    parameter int N_SRC      = 2,
    parameter int LOAD_STAGE = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    freeze_i,
    input  logic                                    ex_valid_i,
    input  logic [REG_ADDR_W-1:0]                   ex_rd_i,
    input  logic                                    ex_regwrite_i,
    input  logic                                    ex_is_load_i,
    input  logic [REG_ADDR_W*N_SRC-1:0]             ex_rs_i,
    input  logic [REG_ADDR_W*N_SRC-1:0]             id_rs_i,
    input  logic [N_SRC-1:0]                        id_rs_used_i,
    output logic [clog2(N_STAGES+1)*N_SRC-1:0]      fwd_sel_o,
    output logic                                    stall_o,
    output logic [31:0]                             fwd_cnt_o,
    output logic [31:0]                             stall_cnt_o
);

    localparam int SELW = clog2(N_STAGES + 1);

    fwd_entry_t                  ex_entry;
    logic [N_STAGES*ENTRY_W-1:0] entries;
    fwd_entry_t                  stage     [1:N_STAGES];
    fwd_entry_t                  pos_entry [0:N_STAGES-1];
    logic [N_SRC-1:0]            stall_vec;
    logic [N_SRC-1:0]            early_vec;

    assign ex_entry.valid   = ex_valid_i & ex_regwrite_i & (ex_rd_i != '0);
    assign ex_entry.rd      = ex_rd_i;
    assign ex_entry.is_load = ex_is_load_i;

    fwd_tag_pipe #(
        .N_STAGES (N_STAGES)
    ) u_tag_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .freeze_i  (freeze_i),
        .entry_i   (ex_entry),
        .entries_o (entries)
    );

    for (genvar gi = 1; gi <= N_STAGES; gi++) begin : g_unpack
        assign stage[gi] = entries[(gi-1)*ENTRY_W +: ENTRY_W];
    end

    // Stall producers: position 0 is the instruction currently in EX.
    assign pos_entry[0] = ex_entry;
    for (genvar gi = 1; gi < N_STAGES; gi++) begin : g_pos
        assign pos_entry[gi] = stage[gi];
    end

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_op
        logic [REG_ADDR_W-1:0] ex_src;
        logic [REG_ADDR_W-1:0] id_src;
        logic [SELW-1:0]       sel;
        logic                  early_load;
        logic                  stall_op;

        assign ex_src = ex_rs_i[gi*REG_ADDR_W +: REG_ADDR_W];
        assign id_src = id_rs_i[gi*REG_ADDR_W +: REG_ADDR_W];

        // Scan oldest to youngest so the youngest matching stage wins.
        always_comb begin
            sel        = SELW'(FWD_SEL_RF);
            early_load = 1'b0;
            for (int k = N_STAGES; k >= 1; k--) begin
                if (entry_match(stage[k], ex_src)) begin
                    sel        = SELW'(k);
                    early_load = stage[k].is_load && (k < LOAD_STAGE);
                end
            end
        end

        // Youngest matching producer decides; a younger non-load masks an older load.
        always_comb begin
            stall_op = 1'b0;
            for (int p = N_STAGES - 1; p >= 0; p--) begin
                if (id_rs_used_i[gi] && entry_match(pos_entry[p], id_src)) begin
                    stall_op = pos_entry[p].is_load && (p + 1 < LOAD_STAGE);
                end
            end
        end

        assign fwd_sel_o[gi*SELW +: SELW] = sel;
        assign stall_vec[gi] = stall_op;
        assign early_vec[gi] = ex_valid_i & early_load;
    end

    assign stall_o = |stall_vec;

    // A load must never be forwarded before it is available once stalls are obeyed.
    a_no_early_load_fwd : assert property (@(posedge clk_i) disable iff (rst_i) !(|early_vec));

`ifdef FWD_STATS_EN
    logic [31:0] fwd_cnt_reg;
    logic [31:0] stall_cnt_reg;

    // Saturating activity counters, counting only unfrozen cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
        end else if (!freeze_i) begin
            if ((|fwd_sel_o) && (fwd_cnt_reg != '1)) begin
                fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
            end
            if (stall_o && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign fwd_cnt_o   = fwd_cnt_reg;
    assign stall_cnt_o = stall_cnt_reg;
`else
    assign fwd_cnt_o   = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard: default configuration plus
// a wide instance (N_STAGES=4, N_SRC=3, LOAD_STAGE=3) on the same clock.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default instance signals
    logic        d_freeze, d_ex_valid, d_ex_rw, d_ex_load;
    logic [4:0]  d_ex_rd;
    logic [9:0]  d_ex_rs, d_id_rs;
    logic [1:0]  d_id_used;
    logic [3:0]  d_sel;
    logic        d_stall;
    logic [31:0] d_fcnt, d_scnt;

    // Wide instance signals
    logic        b_freeze, b_ex_valid, b_ex_rw, b_ex_load;
    logic [4:0]  b_ex_rd;
    logic [14:0] b_ex_rs, b_id_rs;
    logic [2:0]  b_id_used;
    logic [8:0]  b_sel;
    logic        b_stall;
    logic [31:0] b_fcnt, b_scnt;

    int checks = 0;
    int errors = 0;

`ifdef FWD_STATS_EN
    localparam int EXP_FCNT = 4;
    localparam int EXP_SCNT = 2;
`else
    localparam int EXP_FCNT = 0;
    localparam int EXP_SCNT = 0;
`endif

    fwd_scoreboard #(.N_STAGES(2), .N_SRC(2), .LOAD_STAGE(2)) u_dut_def (
        .clk_i(clk), .rst_i(rst), .freeze_i(d_freeze),
        .ex_valid_i(d_ex_valid), .ex_rd_i(d_ex_rd), .ex_regwrite_i(d_ex_rw),
        .ex_is_load_i(d_ex_load), .ex_rs_i(d_ex_rs), .id_rs_i(d_id_rs),
        .id_rs_used_i(d_id_used), .fwd_sel_o(d_sel), .stall_o(d_stall),
        .fwd_cnt_o(d_fcnt), .stall_cnt_o(d_scnt)
    );

    fwd_scoreboard #(.N_STAGES(4), .N_SRC(3), .LOAD_STAGE(3)) u_dut_big (
        .clk_i(clk), .rst_i(rst), .freeze_i(b_freeze),
        .ex_valid_i(b_ex_valid), .ex_rd_i(b_ex_rd), .ex_regwrite_i(b_ex_rw),
        .ex_is_load_i(b_ex_load), .ex_rs_i(b_ex_rs), .id_rs_i(b_id_rs),
        .id_rs_used_i(b_id_used), .fwd_sel_o(b_sel), .stall_o(b_stall),
        .fwd_cnt_o(b_fcnt), .stall_cnt_o(b_scnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic d_ex(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                        input logic [4:0] rs0, input logic [4:0] rs1);
        d_ex_valid = v; d_ex_rd = rd; d_ex_rw = rw; d_ex_load = ld;
        d_ex_rs = {rs1, rs0};
    endtask

    task automatic d_id(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
        d_id_rs = {rs1, rs0}; d_id_used = used;
    endtask

    task automatic b_ex(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                        input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2);
        b_ex_valid = v; b_ex_rd = rd; b_ex_rw = rw; b_ex_load = ld;
        b_ex_rs = {rs2, rs1, rs0};
    endtask

    task automatic b_id(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] used);
        b_id_rs = {rs2, rs1, rs0}; b_id_used = used;
    endtask

    task automatic idle_all();
        d_freeze = 1'b0; b_freeze = 1'b0;
        d_ex(0, 0, 0, 0, 0, 0); d_id(0, 0, 0);
        b_ex(0, 0, 0, 0, 0, 0, 0); b_id(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        do_reset();
        #1;
        checks++; if (d_sel !== 4'd0) begin errors++; $display("FAIL reset_d_sel got %0d want 0", d_sel); end
        else $display("ok   reset_d_sel %0d", d_sel);
        checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL reset_d_stall got %0b want 0", d_stall); end
        else $display("ok   reset_d_stall %0b", d_stall);
        checks++; if (b_sel !== 9'd0 || b_stall !== 1'b0) begin errors++; $display("FAIL reset_b got sel %0d stall %0b want 0 0", b_sel, b_stall); end
        else $display("ok   reset_b sel %0d stall %0b", b_sel, b_stall);
        checks++; if (d_fcnt !== 32'd0 || d_scnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d %0d want 0 0", d_fcnt, d_scnt); end
        else $display("ok   reset_cnt %0d %0d", d_fcnt, d_scnt);
        // reset wins over freeze: an in-flight producer must be cleared
        d_ex(1, 5, 1, 0, 0, 0);
        cyc();
        rst = 1'b1; d_freeze = 1'b1; d_ex(0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0; d_freeze = 1'b0; d_ex(1, 0, 0, 0, 5, 0);
        #1;
        checks++; if (d_sel[1:0] !== 2'd0) begin errors++; $display("FAIL reset_over_freeze got %0d want 0", d_sel[1:0]); end
        else $display("ok   reset_over_freeze %0d", d_sel[1:0]);
        idle_all();
        cyc();
    endtask

    task automatic test_fwd_chain();
        do_reset();
        d_ex(1, 5, 1, 0, 0, 0);
        cyc();
        d_ex(1, 0, 0, 0, 5, 0); #1;
        checks++; if (d_sel[1:0] !== 2'd1) begin errors++; $display("FAIL chain_sel1 got %0d want 1", d_sel[1:0]); end
        else $display("ok   chain_sel1 %0d", d_sel[1:0]);
        cyc(); #1;
        checks++; if (d_sel[1:0] !== 2'd2) begin errors++; $display("FAIL chain_sel2 got %0d want 2", d_sel[1:0]); end
        else $display("ok   chain_sel2 %0d", d_sel[1:0]);
        cyc(); #1;
        checks++; if (d_sel[1:0] !== 2'd0) begin errors++; $display("FAIL chain_sel0 got %0d want 0", d_sel[1:0]); end
        else $display("ok   chain_sel0 %0d", d_sel[1:0]);
        idle_all();
        cyc();
    endtask

    task automatic test_load_use();
        do_reset();
        d_ex(1, 7, 1, 1, 0, 0); d_id(0, 7, 2'b10); #1;
        checks++; if (d_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", d_stall); end
        else $display("ok   lu_stall %0b", d_stall);
        cyc();
        d_ex(0, 0, 0, 0, 0, 0); #1;
        checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0b want 0", d_stall); end
        else $display("ok   lu_release %0b", d_stall);
        cyc();
        d_ex(1, 0, 0, 0, 0, 7); d_id(0, 0, 0); #1;
        checks++; if (d_sel !== 4'b1000) begin errors++; $display("FAIL lu_fwd got %0d want 8", d_sel); end
        else $display("ok   lu_fwd %0d", d_sel);
        idle_all();
        cyc();
    endtask

    task automatic test_youngest();
        do_reset();
        d_ex(1, 3, 1, 0, 0, 0); cyc();
        d_ex(1, 3, 1, 0, 0, 0); cyc();
        d_ex(1, 0, 0, 0, 3, 0); #1;
        checks++; if (d_sel[1:0] !== 2'd1) begin errors++; $display("FAIL young_sel got %0d want 1", d_sel[1:0]); end
        else $display("ok   young_sel %0d", d_sel[1:0]);
        cyc();
        d_ex(1, 3, 1, 1, 0, 0); d_id(3, 0, 2'b01); #1;
        checks++; if (d_stall !== 1'b1) begin errors++; $display("FAIL young_ld_stall got %0b want 1", d_stall); end
        else $display("ok   young_ld_stall %0b", d_stall);
        cyc();
        d_ex(1, 3, 1, 0, 0, 0); #1;
        checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL young_mask got %0b want 0", d_stall); end
        else $display("ok   young_mask %0b", d_stall);
        idle_all();
        cyc();
    endtask

    task automatic test_null();
        do_reset();
        d_ex(1, 0, 1, 1, 0, 0); d_id(0, 0, 2'b01); #1;
        checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL null_x0_stall got %0b want 0", d_stall); end
        else $display("ok   null_x0_stall %0b", d_stall);
        cyc();
        d_ex(0, 4, 1, 1, 0, 0); d_id(4, 0, 2'b01); #1;
        checks++; if (d_sel !== 4'd0 || d_stall !== 1'b0) begin errors++; $display("FAIL null_inval got sel %0d stall %0b want 0 0", d_sel, d_stall); end
        else $display("ok   null_inval sel %0d stall %0b", d_sel, d_stall);
        cyc();
        d_ex(1, 8, 1, 1, 4, 0); d_id(0, 8, 2'b00); #1;
        checks++; if (d_sel !== 4'd0 || d_stall !== 1'b0) begin errors++; $display("FAIL null_unused got sel %0d stall %0b want 0 0", d_sel, d_stall); end
        else $display("ok   null_unused sel %0d stall %0b", d_sel, d_stall);
        idle_all();
        cyc();
    endtask

    task automatic test_freeze();
        do_reset();
        d_ex(1, 10, 1, 0, 0, 0); cyc();
        d_ex(1, 0, 0, 0, 10, 0); d_freeze = 1'b1; #1;
        checks++; if (d_sel[1:0] !== 2'd1) begin errors++; $display("FAIL frz_start got %0d want 1", d_sel[1:0]); end
        else $display("ok   frz_start %0d", d_sel[1:0]);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            checks++; if (d_sel[1:0] !== 2'd1) begin errors++; $display("FAIL frz_hold%0d got %0d want 1", i, d_sel[1:0]); end
            else $display("ok   frz_hold%0d %0d", i, d_sel[1:0]);
        end
        d_freeze = 1'b0;
        cyc(); #1;
        checks++; if (d_sel[1:0] !== 2'd2) begin errors++; $display("FAIL frz_release got %0d want 2", d_sel[1:0]); end
        else $display("ok   frz_release %0d", d_sel[1:0]);
        idle_all();
        cyc();
    endtask

    task automatic test_big();
        do_reset();
        b_ex(1, 9, 1, 1, 0, 0, 0); b_id(0, 0, 9, 3'b100); #1;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL big_stall0 got %0b want 1", b_stall); end
        else $display("ok   big_stall0 %0b", b_stall);
        cyc();
        b_ex(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL big_stall1 got %0b want 1", b_stall); end
        else $display("ok   big_stall1 %0b", b_stall);
        cyc(); #1;
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL big_release got %0b want 0", b_stall); end
        else $display("ok   big_release %0b", b_stall);
        cyc();
        b_ex(1, 0, 0, 0, 0, 0, 9); b_id(0, 0, 0, 3'b000); #1;
        checks++; if (b_sel !== 9'b011_000_000) begin errors++; $display("FAIL big_fwd3 got %0h want c0", b_sel); end
        else $display("ok   big_fwd3 %0h", b_sel);
        cyc();
        b_ex(1, 9, 1, 1, 9, 0, 0); b_id(0, 0, 9, 3'b100); #1;
        checks++; if (b_stall !== 1'b1 || b_sel !== 9'd4) begin errors++; $display("FAIL big_pre_rst got stall %0b sel %0h want 1 4", b_stall, b_sel); end
        else $display("ok   big_pre_rst stall %0b sel %0h", b_stall, b_sel);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        b_ex(0, 0, 0, 0, 9, 0, 0); #1;
        checks++; if (b_stall !== 1'b0 || b_sel !== 9'd0) begin errors++; $display("FAIL big_post_rst got stall %0b sel %0h want 0 0", b_stall, b_sel); end
        else $display("ok   big_post_rst stall %0b sel %0h", b_stall, b_sel);
        idle_all();
        cyc();
    endtask

    task automatic test_stats();
        do_reset();
        d_ex(1, 1, 1, 0, 0, 0); cyc();                      // producer x1
        d_ex(1, 0, 0, 0, 1, 0); cyc();                      // fwd from stage 1
        cyc();                                              // fwd from stage 2
        d_ex(1, 2, 1, 1, 0, 0); d_id(2, 0, 2'b01); cyc();  // lw x2, stall
        d_ex(0, 0, 0, 0, 0, 0); cyc();                      // bubble
        d_ex(1, 0, 0, 0, 2, 0); d_id(0, 0, 0); cyc();      // fwd from stage 2
        d_ex(1, 3, 1, 1, 0, 0); d_id(0, 3, 2'b10); cyc();  // lw x3, stall
        d_ex(0, 0, 0, 0, 0, 0); cyc();                      // bubble
        d_ex(1, 0, 0, 0, 0, 3); d_id(0, 0, 0); cyc();      // fwd from stage 2
        idle_all(); cyc();
        #1;
        checks++; if (d_fcnt !== 32'(EXP_FCNT)) begin errors++; $display("FAIL stats_fwd got %0d want %0d", d_fcnt, EXP_FCNT); end
        else $display("ok   stats_fwd %0d", d_fcnt);
        checks++; if (d_scnt !== 32'(EXP_SCNT)) begin errors++; $display("FAIL stats_stall got %0d want %0d", d_scnt, EXP_SCNT); end
        else $display("ok   stats_stall %0d", d_scnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fwd_chain();
        test_load_use();
        test_youngest();
        test_null();
        test_freeze();
        test_big();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
Parametrised forwarding and hazard controller for the pipelined RISC-V core. It replaces the fixed two-stage compare logic with an internal tag pipeline. The tag pipeline records destination register, write-enable and load-flag of every instruction leaving EX, for N_STAGES downstream stages. From this state it produces per-operand forward selects for the EX instruction and a load-use stall for the ID instruction. It sits beside the ID/EX register and drives the operand muxes and the PC/IF-ID hold logic.

Parameters:
N_STAGES, 2, downstream stages tracked after EX (stage 1 = EX/MEM, 2 = MEM/WB, ...); range 1..7
N_SRC, 2, source operands per instruction (2 = rs1/rs2, 3 adds rs3 for FMA-style ops)
LOAD_STAGE, 2, first stage index at which a load's result is forwardable; range 1..N_STAGES
SELW (localparam), clog2(N_STAGES+1), width of one forward select

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
freeze_i  in  1  whole pipeline frozen (cache miss); tag pipe holds
ex_valid_i  in  1  EX holds a real instruction (0 = bubble/flushed)
ex_rd_i  in  5  EX destination register
ex_regwrite_i  in  1  EX instruction writes rd
ex_is_load_i  in  1  EX instruction is a load
ex_rs_i  in  5*N_SRC  EX source registers, operand j at [5j+4:5j]
id_rs_i  in  5*N_SRC  ID source registers, same packing
id_rs_used_i  in  N_SRC  ID operand j actually read
fwd_sel_o  out  SELW*N_SRC  per-operand select: 0 = register file, k = stage k
stall_o  out  1  load-use hazard; hold PC and IF/ID, bubble into EX
fwd_cnt_o  out  32  cycles with any nonzero forward select (optional feature)
stall_cnt_o  out  32  cycles with stall_o=1 and freeze_i=0 (optional feature)

Behaviour:
- Reset: one clock, synchronous, active-high. rst_i=1 at a clock edge clears all stage entries (valid=0, rd=0, flags=0) and both counters; rst_i wins over freeze_i.
- Outputs are combinational from registered state. After reset, fwd_sel_o=0 and stall_o=0 from the following cycle.
- Tag pipe update, each edge with rst_i=0 and freeze_i=0:
  - stage k+1 takes stage k, for k = 1..N_STAGES-1;
  - stage 1 takes {ex_valid_i & ex_regwrite_i & (ex_rd_i != 0), ex_rd_i, ex_is_load_i};
  - the stage-N_STAGES entry is dropped.
- With freeze_i=1 all entries hold. Latency: an instruction in EX at cycle t occupies stage k at cycle t+k, absent freezes.
- Entry match: entry valid and rd equals the compared source. Register x0 never matches; invalid entries never match.
- Forward select, per operand j:
  - the lowest (youngest) stage k in 1..N_STAGES whose entry matches ex_rs_i[j], else 0;
  - a younger match always overrides an older one.
- Stall:
  - Candidate producers are positions p = 0..N_STAGES-1. Position 0 is the current EX instruction (valid & regwrite & rd != 0); position k is stage k.
  - For each ID operand with id_rs_used_i=1, take the youngest matching position p.
  - stall_o=1 if any such producer is a load with p+1 < LOAD_STAGE.
  - A younger non-load match masks an older load, so no stall in that case.
- Stall cycle: the core inserts a bubble (ex_valid_i=0). The load advances one stage, and stall_o deasserts once the load reaches forwardable distance. Default config gives exactly one stall cycle.
- freeze_i=1 does not alter stall_o or fwd_sel_o evaluation; they are still driven from held state.
- Writeback stage N_STAGES to ID same-cycle read is handled by register file write-through. No forwarding is done beyond N_STAGES.
- If a matched stage k < LOAD_STAGE holds a load, the select is still k. Simulation assertion: this never occurs while stall_o is honoured.

Optional Feature:
- Macro: FWD_STATS_EN.
- Defined:
  - fwd_cnt_o increments each unfrozen cycle where any fwd_sel_o operand is nonzero;
  - stall_cnt_o increments each cycle with stall_o=1 and freeze_i=0;
  - both saturate at 32'hFFFF_FFFF and are cleared by rst_i.
- Undefined: counters are not built and both ports are tied to 0. Port list is identical either way.

Decomposition:
- Shared package fwd_pkg: REG_ADDR_W=5; FWD_SEL_RF=0; entry struct typedef {valid, rd, is_load}; clog2 helper function.
- One sub-module fwd_tag_pipe: parametrised N_STAGES shift register with hold and sync reset, exposing all entries flattened.
- Compare/priority logic and counters stay in fwd_scoreboard.

Test Plan:
- Defaults. Step 1: add x5 in EX, next cycle EX reads rs1=x5 → fwd_sel_o[op0]=1. Step 2: one more cycle with a bubble in between → sel=2. Step 3: a third cycle later → sel=0.
- Defaults. Step 1: lw x7 in EX while ID has rs2=x7, used → stall_o=1 for one cycle. Step 2: after the bubble, stall_o=0 and the EX consumer gets fwd_sel_o[op1]=2.
- Youngest wins: addi x3 in stage 2 and addi x3 in stage 1 → sel=1. Also lw x3 at position 1 masked by addi x3 at position 0 → stall_o=0.
- rd=x0 with regwrite, or ex_valid_i=0, or id_rs_used_i=0 → no forward, no stall. Separately, freeze_i=1 for 3 cycles holds sel=1 constant.
- N_STAGES=4, LOAD_STAGE=3, N_SRC=3. Step 1: lw x9 in EX with ID rs3=x9 → 2 stall cycles. Step 2: consumer then forwards from stage 3. Step 3: rst_i asserted mid-stall → stall_o=0 and all sel=0 the next cycle.
- FWD_STATS_EN defined, 10-cycle mix of 4 forward cycles and 2 stall cycles → fwd_cnt_o=4, stall_cnt_o=2. Undefined → both read 0.
